change_dispenser: RTL and testbench

//  Consumer of the vending machine's change output: takes the change amount r[2:0]
//  (cents, 0-7) and pays it out as discrete coin-eject pulses to a 2-cent and a
//  1-cent hopper, one coin at a time with a req/ack handshake per coin.

---
 rtl/change_dispenser.sv | 112 +++++++++++
 tb/tb_change_dispenser.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Pays a change amount out as individual 2-cent / 1-cent coin ejects, one req/ack
// handshake per coin, with a one-deep pending buffer, overrun flag and ack timeout.
module change_dispenser #(
    parameter int R_WIDTH     = 3,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [R_WIDTH-1:0] r,
    input  logic               two_empty,
    input  logic               hopper_ack,
    input  logic               clr_fault,
    output logic               pay_two,
    output logic               pay_one,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic               overrun
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SELECT, PAY, GAP, DONE, FAULT} state_t;

    state_t             state, state_next;
    logic [R_WIDTH-1:0] remaining;
    logic [R_WIDTH-1:0] pending;
    logic               pend_valid;
    logic               coin;
    logic [TW-1:0]      timer;
    logic               overrun_q;
    logic               r_cap;
    logic               slot_free;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (r != '0) state_next = SELECT;
            SELECT: state_next = (remaining == '0) ? DONE : PAY;
            PAY: begin
                if (hopper_ack)                          state_next = GAP;
                else if (timer == TW'(ACK_TIMEOUT - 1))  state_next = FAULT;
            end
            GAP:    if (!hopper_ack) state_next = SELECT;
            DONE:   state_next = pend_valid ? SELECT : IDLE;
            FAULT:  if (clr_fault) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pay_two = (state == PAY) &&  coin;
        pay_one = (state == PAY) && !coin;
        busy    = (state != IDLE);
        done    = (state == DONE);
        fault   = (state == FAULT);
        overrun = overrun_q;
    end

    // A load out of the pending slot in DONE frees it for a request arriving that same cycle.
    assign r_cap     = (state != IDLE) && (r != '0);
    assign slot_free = !pend_valid || (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            coin      <= 1'b0;
            timer     <= '0;
        end else begin
            case (state)
                IDLE:   if (r != '0) remaining <= r;
                SELECT: begin
                    coin  <= (remaining >= R_WIDTH'(2)) && !two_empty;
                    timer <= '0;
                end
                PAY: begin
                    if (hopper_ack) remaining <= remaining - (coin ? R_WIDTH'(2) : R_WIDTH'(1));
                    else            timer     <= timer + TW'(1);
                end
                DONE:   if (pend_valid) remaining <= pending;
                FAULT:  if (clr_fault) remaining <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            pend_valid <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (state == FAULT && clr_fault) begin
                pend_valid <= 1'b0;
            end else if (r_cap && slot_free) begin
                pending    <= r;
                pend_valid <= 1'b1;
            end else if (state == DONE && pend_valid) begin
                pend_valid <= 1'b0;
            end

            if (clr_fault)                 overrun_q <= 1'b0;
            else if (r_cap && !slot_free)  overrun_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a hopper responder with random ack delay,
// and a reference model that predicts coin sequences from the change amounts.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] r;
    logic       two_empty;
    logic       hopper_ack = 1'b0;
    logic       clr_fault;
    logic       pay_two, pay_one, busy, done, fault, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    bit both_seen = 1'b0;
    bit ack_en = 1'b1;
    int ack_delay = 0;
    int wait_cnt = 0;
    int obs_coins[$];
    int exp_coins[$];

    change_dispenser #(.R_WIDTH(3), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .r(r), .two_empty(two_empty),
        .hopper_ack(hopper_ack), .clr_fault(clr_fault),
        .pay_two(pay_two), .pay_one(pay_one), .busy(busy),
        .done(done), .fault(fault), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Hopper: acks each eject after a random delay, then drops ack once the eject drops.
    always @(negedge clk) begin
        if (!reset || !ack_en) begin
            hopper_ack = 1'b0;
            wait_cnt   = 0;
        end else if ((pay_two || pay_one) && !hopper_ack) begin
            if (wait_cnt >= ack_delay) begin
                hopper_ack = 1'b1;
                obs_coins.push_back(pay_two ? 2 : 1);
                wait_cnt  = 0;
                ack_delay = $urandom_range(0, 3);
            end else begin
                wait_cnt++;
            end
        end else if (hopper_ack && !pay_two && !pay_one) begin
            hopper_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (pay_two && pay_one) both_seen = 1'b1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Largest coin first: as many 2s as fit (unless the 2-cent hopper is empty), then 1s.
    task automatic model(input int amt, input bit te);
        int twos = te ? 0 : amt / 2;
        int ones = amt - 2 * twos;
        repeat (twos) exp_coins.push_back(2);
        repeat (ones) exp_coins.push_back(1);
    endtask

    task automatic compare_coins(input string tag);
        check({tag, "_ncoins"}, obs_coins.size(), exp_coins.size());
        for (int i = 0; i < exp_coins.size() && i < obs_coins.size(); i++)
            check({tag, "_coin"}, obs_coins[i], exp_coins[i]);
        obs_coins.delete();
        exp_coins.delete();
    endtask

    task automatic send(input int amt);
        @(negedge clk);
        r = 3'(amt);
        @(negedge clk);
        r = '0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic run_txn(input string tag, input int amt, input bit te);
        int d0;
        two_empty = te;
        d0 = done_cnt;
        model(amt, te);
        send(amt);
        wait_idle(tag, 300);
        check({tag, "_done"}, done_cnt - d0, 1);
        compare_coins(tag);
    endtask

    initial begin
        int d0, n, a1, a2, a3;
        bit te;
        reset = 1'b0; r = '0; two_empty = 1'b0; clr_fault = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pay_two", int'(pay_two), 0);
        check("rst_pay_one", int'(pay_one), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);

        run_txn("r3", 3, 1'b0);
        run_txn("r5_empty", 5, 1'b1);
        for (int i = 0; i < 20; i++)
            run_txn("rand", $urandom_range(1, 7), 1'(($urandom_range(0, 3) == 0)));

        // Ack timeout: the eject is held 15 cycles, then FAULT.
        ack_en = 1'b0;
        two_empty = 1'b0;
        send(4);
        n = 0;
        for (int i = 0; i < 60 && !fault; i++) begin
            if (pay_two) n++;
            @(negedge clk);
        end
        check("to_pay_cycles", n, 15);
        check("to_fault", int'(fault), 1);
        check("to_busy", int'(busy), 1);
        check("to_pay_low", int'(pay_two || pay_one), 0);
        @(negedge clk); clr_fault = 1'b1;
        @(negedge clk); clr_fault = 1'b0;
        check("clr_fault", int'(fault), 0);
        check("clr_busy", int'(busy), 0);
        obs_coins.delete();
        ack_en = 1'b1;

        // Pending capture and overrun: second request buffered, third dropped.
        for (int k = 0; k < 3; k++) begin
            a1 = $urandom_range(2, 7);
            a2 = $urandom_range(1, 7);
            a3 = $urandom_range(1, 7);
            te = 1'(($urandom_range(0, 2) == 0));
            two_empty = te;
            d0 = done_cnt;
            model(a1, te);
            model(a2, te);
            send(a1);
            r = 3'(a2);
            @(negedge clk); r = 3'(a3);
            @(negedge clk); r = '0;
            wait_idle("pend", 400);
            check("pend_done", done_cnt - d0, 2);
            check("pend_overrun", int'(overrun), 1);
            compare_coins("pend");
            @(negedge clk); clr_fault = 1'b1;
            @(negedge clk); clr_fault = 1'b0;
            check("ovr_clr", int'(overrun), 0);
            check("ovr_clr_busy", int'(busy), 0);
        end

        // Reset while a 2-cent eject is in flight.
        ack_en = 1'b0;
        two_empty = 1'b0;
        send(6);
        for (int i = 0; i < 10 && !pay_two; i++) @(negedge clk);
        check("mid_pay_two", int'(pay_two), 1);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        check("mid_rst_pay_two", int'(pay_two), 0);
        check("mid_rst_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_done", done_cnt - d0, 0);
        reset = 1'b1;
        obs_coins.delete();
        ack_en = 1'b1;
        run_txn("after_rst", 7, 1'b0);

        check("never_both", int'(both_seen), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
